// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with same-cycle write bypass and a busy-bit scoreboard.
// Higher write lanes take priority on address collisions, for both storage and bypass.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_WR-1:0]          wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
  input  logic                       alloc_en_i,
  input  logic [ADDR_W-1:0]          alloc_addr_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  output logic [CNT_W-1:0]           busy_count_o
);
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  busy_count_q, busy_count_d;

  // Lanes are applied in ascending order so the highest index lands last.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NUM_WR; i++)
      if (wr_en_i[i] && !(ZERO_REG != 0 && wr_addr_i[i*ADDR_W +: ADDR_W] == '0)) begin
        regs_d[wr_addr_i[i*ADDR_W +: ADDR_W]] = wr_data_i[i*DATA_W +: DATA_W];
        busy_d[wr_addr_i[i*ADDR_W +: ADDR_W]] = 1'b0;
      end
    if (alloc_en_i) busy_d[alloc_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_count_d = '0;
    for (int r = 0; r < DEPTH; r++)
      busy_count_d = busy_count_d + CNT_W'(busy_d[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q       <= '{default: '0};
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // A bypassed read gets its data from the writer, so it is no longer waiting on it.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rd_data_o[j*DATA_W +: DATA_W] = regs_q[rd_addr_i[j*ADDR_W +: ADDR_W]];
      rd_busy_o[j] = busy_q[rd_addr_i[j*ADDR_W +: ADDR_W]];
      for (int i = 0; i < NUM_WR; i++)
        if (BYPASS != 0 && wr_en_i[i] && wr_addr_i[i*ADDR_W +: ADDR_W] == rd_addr_i[j*ADDR_W +: ADDR_W]) begin
          rd_data_o[j*DATA_W +: DATA_W] = wr_data_i[i*DATA_W +: DATA_W];
          rd_busy_o[j] = 1'b0;
        end
      if (ZERO_REG != 0 && rd_addr_i[j*ADDR_W +: ADDR_W] == '0) begin
        rd_data_o[j*DATA_W +: DATA_W] = '0;
        rd_busy_o[j] = 1'b0;
      end
    end
  end

  assign busy_count_o = busy_count_q;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed checks of a 2R/2W bypassing file and a 4R/1W non-bypassing file.
module tb_regfile_mp_sb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        alloc_en = 1'b0;
  logic [4:0]  alloc_addr = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [5:0]  busy_count;

  logic        b_wr_en = 1'b0;
  logic [4:0]  b_wr_addr = '0;
  logic [31:0] b_wr_data = '0;
  logic        b_alloc_en = 1'b0;
  logic [4:0]  b_alloc_addr = '0;
  logic [19:0] b_rd_addr = '0;
  logic [127:0] b_rd_data;
  logic [3:0]  b_rd_busy;
  logic [5:0]  b_busy_count;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  regfile_mp_sb dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_busy_o(rd_busy), .busy_count_o(busy_count)
  );

  regfile_mp_sb #(.NUM_RD(4), .NUM_WR(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
    .alloc_en_i(b_alloc_en), .alloc_addr_i(b_alloc_addr), .rd_addr_i(b_rd_addr),
    .rd_data_o(b_rd_data), .rd_busy_o(b_rd_busy), .busy_count_o(b_busy_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int lane, input logic [4:0] a, input logic [31:0] d);
    wr_en[lane] = 1'b1;
    wr_addr[lane*5 +: 5] = a;
    wr_data[lane*32 +: 32] = d;
  endtask

  task automatic idle();
    wr_en = '0;
    alloc_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    #3;
    check("rst_count", 64'(busy_count), 0);
    #9 rst_n = 1'b1;
    for (int r = 0; r < 32; r++) begin
      rd(5'(r), 5'(31 - r));
      check("rst_rd0", 64'(rd_data[31:0]), 0);
      check("rst_rd1", 64'(rd_data[63:32]), 0);
      check("rst_busy", 64'(rd_busy), 0);
    end
    check("rst_count_rel", 64'(busy_count), 0);

    tick();
    wr(0, 5, 32'hDEADBEEF);
    tick();
    idle();
    rd(5, 0);
    check("wr_r5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    wr(1, 0, 32'h1234);
    rd(5, 0);
    check("r0_bypass", 64'(rd_data[63:32]), 0);
    tick();
    idle();
    rd(5, 0);
    check("r0_stored", 64'(rd_data[63:32]), 0);

    wr(0, 7, 32'h11111111);
    wr(1, 7, 32'h22222222);
    rd(7, 7);
    check("coll_byp1", 64'(rd_data[63:32]), 64'h22222222);
    check("coll_byp0", 64'(rd_data[31:0]), 64'h22222222);
    tick();
    idle();
    rd(5, 7);
    check("coll_store", 64'(rd_data[63:32]), 64'h22222222);
    check("r5_kept", 64'(rd_data[31:0]), 64'hDEADBEEF);

    alloc_en = 1'b1;
    alloc_addr = 3;
    rd(3, 3);
    check("alloc_same_cyc", 64'(rd_busy), 0);
    tick();
    idle();
    rd(3, 4);
    check("sb_busy", 64'(rd_busy), 64'b01);
    check("sb_count1", 64'(busy_count), 1);
    wr(0, 3, 32'hA5);
    rd(3, 3);
    check("sb_byp_busy", 64'(rd_busy), 0);
    check("sb_byp_data", rd_data, {32'hA5, 32'hA5});
    tick();
    idle();
    rd(3, 3);
    check("sb_count0", 64'(busy_count), 0);
    check("sb_clear", 64'(rd_busy), 0);
    check("sb_data", 64'(rd_data[31:0]), 64'hA5);

    alloc_en = 1'b1;
    alloc_addr = 9;
    tick();
    idle();
    rd(9, 9);
    check("race_pre", 64'(busy_count), 1);
    alloc_en = 1'b1;
    alloc_addr = 9;
    wr(0, 9, 32'h77);
    rd(9, 9);
    check("race_byp", 64'(rd_data[31:0]), 64'h77);
    check("race_byp_busy", 64'(rd_busy), 0);
    tick();
    idle();
    rd(9, 9);
    check("race_data", 64'(rd_data[31:0]), 64'h77);
    check("race_busy", 64'(rd_busy), 64'b11);
    check("race_count", 64'(busy_count), 1);
    wr(1, 9, 32'h88);
    tick();
    idle();
    rd(9, 0);
    check("race_done", 64'(busy_count), 0);
    check("race_done_data", 64'(rd_data[31:0]), 64'h88);

    alloc_en = 1'b1;
    alloc_addr = 0;
    tick();
    idle();
    rd(0, 0);
    check("r0_alloc_cnt", 64'(busy_count), 0);
    check("r0_alloc_busy", 64'(rd_busy), 0);

    alloc_en = 1'b1;
    alloc_addr = 1;
    tick();
    alloc_addr = 2;
    tick();
    alloc_addr = 3;
    wr(0, 4, 32'h99);
    tick();
    idle();
    rd(1, 4);
    check("mid_count", 64'(busy_count), 3);
    check("mid_r4", 64'(rd_data[63:32]), 64'h99);
    alloc_en = 1'b1;
    alloc_addr = 6;
    wr(1, 6, 32'h66);
    #2 rst_n = 1'b0;
    #1;
    check("ar_count", 64'(busy_count), 0);
    idle();
    rd(1, 2);
    check("ar_r1r2", rd_data, 0);
    check("ar_busy12", 64'(rd_busy), 0);
    rd(3, 4);
    check("ar_r3r4", rd_data, 0);
    check("ar_busy34", 64'(rd_busy), 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    rd(6, 5);
    check("post_rel_cnt", 64'(busy_count), 0);
    check("post_rel_data", rd_data, 0);

    b_wr_en = 1'b1;
    b_wr_addr = 10;
    b_wr_data = 32'hAAAA;
    tick();
    b_wr_data = 32'hBBBB;
    b_rd_addr = {5'd10, 5'd0, 5'd0, 5'd10};
    #1;
    check("b_old3", 64'(b_rd_data[127:96]), 64'hAAAA);
    check("b_old0", 64'(b_rd_data[31:0]), 64'hAAAA);
    tick();
    b_wr_en = 1'b0;
    b_rd_addr = {5'd0, 5'd10, 5'd0, 5'd0};
    #1;
    check("b_new2", 64'(b_rd_data[95:64]), 64'hBBBB);
    b_alloc_en = 1'b1;
    b_alloc_addr = 11;
    tick();
    b_alloc_en = 1'b0;
    b_wr_en = 1'b1;
    b_wr_addr = 11;
    b_wr_data = 32'hC0DE;
    b_rd_addr = {5'd0, 5'd0, 5'd11, 5'd0};
    #1;
    check("b_nobyp_busy", 64'(b_rd_busy), 64'b0010);
    check("b_nobyp_data", 64'(b_rd_data[63:32]), 0);
    check("b_count1", 64'(b_busy_count), 1);
    tick();
    b_wr_en = 1'b0;
    #1;
    check("b_clear_busy", 64'(b_rd_busy), 0);
    check("b_count0", 64'(b_busy_count), 0);
    check("b_data", 64'(b_rd_data[63:32]), 64'hC0DE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file for the pipelined core. It has NUM_WR synchronous write ports (one per writeback lane) and NUM_RD combinational read ports (ID stage). An optional same-cycle write-to-read bypass is provided. An integrated busy-bit scoreboard lets ID detect pending producers without a separate hazard table. It replaces the single-write/2-read file; registers are now cleared by reset.

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of architectural registers (power of 2, >=2); ADDR_W = clog2(DEPTH) is derived locally
NUM_RD, 2, number of read ports (1..8)
NUM_WR, 2, number of write ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, and is never marked busy
BYPASS, 1, 1 = a read of a register being written this cycle returns the write data

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  NUM_WR  per-lane write enable
wr_addr  in  NUM_WR*ADDR_W  write addresses, lane i at [i*ADDR_W +: ADDR_W]
wr_data  in  NUM_WR*DATA_W  write data, lane i at [i*DATA_W +: DATA_W]
alloc_en  in  1  ID issues an instruction with destination alloc_addr; marks it busy
alloc_addr  in  ADDR_W  destination being allocated
rd_addr  in  NUM_RD*ADDR_W  read addresses, flattened
rd_data  out  NUM_RD*DATA_W  read data, flattened, combinational
rd_busy  out  NUM_RD  1 = register has an outstanding producer, combinational
busy_count  out  clog2(DEPTH+1)  number of registers currently busy (registered)

Behaviour:
- Reset (rst_n low, async): all registers go to 0, all busy bits to 0, and busy_count to 0. Outputs reflect this immediately.
- Write: at posedge, for each lane with wr_en=1, reg[wr_addr] <= wr_data.
  - Writes to address 0 are discarded when ZERO_REG=1.
  - Same-address collision between lanes: the highest-index lane wins, for both the stored value and the bypass value.
- Read: rd_data[j] is combinational with no latency.
  - If ZERO_REG=1 and rd_addr[j]==0, it returns 0.
  - Else, if BYPASS=1 and any enabled lane targets rd_addr[j], it returns that lane's wr_data (highest index wins).
  - Otherwise it returns the stored value.
- Scoreboard, next-state per register r:
  - set if alloc_en && alloc_addr==r;
  - else clear if any enabled write lane targets r;
  - else hold.
  - Alloc wins over a same-cycle write to the same register, because the new producer supersedes the old one.
  - With ZERO_REG=1, register 0 is never set.
- rd_busy[j]:
  - Equals busy_q[rd_addr[j]] masked to 0 if BYPASS=1 and an enabled write targets rd_addr[j] this cycle, since the data is supplied by the bypass.
  - Does not reflect the same-cycle alloc; ID must compare against its own destination.
  - Always 0 for address 0 when ZERO_REG=1.
- busy_count is updated at posedge to the population count of the next-state busy vector. It never exceeds DEPTH (or DEPTH-1 with ZERO_REG=1).
- Writes to a non-busy register are legal: data is stored and the busy bit stays 0.
- Out-of-range addresses cannot occur (DEPTH is a power of 2).
- Reset asserted mid-cycle, while writes or allocs are pending, discards them. Nothing is committed on the first edge after reset release unless the inputs are valid on that edge.

Test Plan:
- Reset then read all addresses: reset, release, read r0..r31 on both ports -> all rd_data=0, rd_busy=0, busy_count=0.
- Basic write/readback with x0 protection:
  - lane0 writes r5=0xDEADBEEF;
  - the next cycle rd_addr0=5 -> rd_data0=0xDEADBEEF;
  - lane1 writes r0=0x1234 -> reading r0 returns 0.
- Lane collision and bypass:
  - same cycle lane0 r7=0x11111111, lane1 r7=0x22222222, rd_addr1=7 -> rd_data1=0x22222222 combinationally;
  - the next cycle stored r7=0x22222222.
- Scoreboard lifecycle:
  - alloc r3 -> next cycle rd_busy=1, busy_count=1;
  - write r3=0xA5 -> same cycle rd_busy=0 and rd_data=0xA5 via bypass;
  - next cycle busy_count=0.
- Alloc/write race:
  - r9 busy; in the same cycle alloc r9 and lane0 writes r9=0x77 -> next cycle r9=0x77 stored, rd_busy=1, busy_count unchanged.
- Async reset mid-operation:
  - alloc r1, r2, r3 and write r4=0x99, then assert rst_n between edges -> immediately busy_count=0, reads of r1..r4 return 0 and not busy.
  - Rerun with NUM_RD=4, NUM_WR=1, BYPASS=0: a same-cycle read of a register being written returns the old value.
